// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back/write-allocate data cache, 8 lines x 4 bytes.
// Optional performance counters are enabled with `define DCACHE_PERF_EN.
//
// state     | meaning
// IDLE      | serve hits; on a miss pick writeback or fetch
// WRITEBACK | write the dirty victim block to memory
// FETCH     | read the requested block from memory and fill the line
module dcache_direct_mapped (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_address,
  input  logic [7:0]  cpu_writedata,
  output logic [7:0]  cpu_readdata,
  output logic        cpu_busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
`ifdef DCACHE_PERF_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t state, next_state;

  logic [31:0] data_array [8];
  logic [2:0]  tag_array  [8];
  logic [7:0]  valid;
  logic [7:0]  dirty;

  logic [2:0]  addr_tag;
  logic [2:0]  addr_index;
  logic [1:0]  addr_offset;
  logic [31:0] line_data;
  logic        hit;
  logic        cpu_req;
  logic        fill_done;

  assign addr_tag     = cpu_address[7:5];
  assign addr_index   = cpu_address[4:2];
  assign addr_offset  = cpu_address[1:0];
  assign line_data    = data_array[addr_index];
  assign hit          = valid[addr_index] && (tag_array[addr_index] == addr_tag);
  assign cpu_req      = cpu_read | cpu_write;
  assign cpu_readdata = line_data[{addr_offset, 3'b000} +: 8];
  assign fill_done    = (state == FETCH) && !mem_busywait;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    cpu_busywait  = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = cpu_address[7:2];
    mem_writedata = line_data;
    case (state)
      IDLE: begin
        if (cpu_req && !hit) begin
          cpu_busywait = 1'b1;
          next_state   = (valid[addr_index] && dirty[addr_index]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        mem_write    = 1'b1;
        mem_address  = {tag_array[addr_index], addr_index};
        cpu_busywait = 1'b1;
        if (!mem_busywait) next_state = FETCH;
      end
      FETCH: begin
        mem_read     = 1'b1;
        cpu_busywait = 1'b1;
        if (!mem_busywait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Both-high requests count as stores, so only cpu_write gates the update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        data_array[i] <= '0;
        tag_array[i]  <= '0;
      end
      valid <= '0;
      dirty <= '0;
    end else begin
      if (state == IDLE && cpu_write && hit) begin
        data_array[addr_index][{addr_offset, 3'b000} +: 8] <= cpu_writedata;
        dirty[addr_index] <= 1'b1;
      end
      if (fill_done) begin
        data_array[addr_index] <= mem_readdata;
        tag_array[addr_index]  <= addr_tag;
        valid[addr_index]      <= 1'b1;
        dirty[addr_index]      <= 1'b0;
      end
    end
  end

`ifdef DCACHE_PERF_EN
  logic just_filled;

  // The completion right after a fill belongs to the miss, not a hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      just_filled <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      just_filled <= fill_done;
      if (state == IDLE && cpu_req && !hit && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
      if (state == IDLE && cpu_req && hit && !just_filled && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Self-checking bench for dcache_direct_mapped with a small latency-configurable memory.
// Counter checks are included when DCACHE_PERF_EN is defined.
module tb_dcache_direct_mapped;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_address = 8'h00;
  logic [7:0]  cpu_writedata = 8'h00;
  logic [7:0]  cpu_readdata;
  logic        cpu_busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
`ifdef DCACHE_PERF_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  logic [31:0] mem [64];
  int          mem_cnt = 0;
  int          mem_latency = 0;
  logic [5:0]  wb_addr = 6'h3F;
  logic [31:0] wb_data = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dcache_direct_mapped dut (
    .clock(clock), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
    .cpu_readdata(cpu_readdata), .cpu_busywait(cpu_busywait),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef DCACHE_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // Memory: busy for mem_latency cycles of an outstanding request.
  assign mem_readdata = mem[mem_address];
  assign mem_busywait = (mem_read | mem_write) && (mem_cnt < mem_latency);

  always @(posedge clock) begin
    if ((mem_read | mem_write) && mem_busywait) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
    if (mem_write && !mem_busywait) begin
      wb_addr <= mem_address;
      wb_data <= mem_writedata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clock);
    #1;
  endtask

  typedef struct {
    string      name;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_busy;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];
  int   n;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {8'hF0 + 8'(i), 8'hE0, 8'hD0, 8'(i)};
    mem[0] = 32'h44332211;
    mem[8] = 32'h88776655;

    vecs[0] = '{"rd_01",   1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h22};
    vecs[1] = '{"wr_02",   1'b0, 1'b1, 8'h02, 8'hAB, 1'b0, 8'h33};
    vecs[2] = '{"rd_02",   1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'hAB};
    vecs[3] = '{"idle_03", 1'b0, 1'b0, 8'h03, 8'h00, 1'b0, 8'h44};
    vecs[4] = '{"idle_00", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h11};

    // Reset state
    #2;
    chk("rst_busy", {31'b0, cpu_busywait}, 0);
    chk("rst_mem_read", {31'b0, mem_read}, 0);
    chk("rst_mem_write", {31'b0, mem_write}, 0);
    chk("rst_rdata", {24'b0, cpu_readdata}, 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Scenario 1: clean miss on 0x00, single-cycle memory
    mem_latency = 0;
    cpu_read = 1'b1; cpu_address = 8'h00;
    #1;
    chk("s1_busy_idle", {31'b0, cpu_busywait}, 1);
    chk("s1_no_req_idle", {30'b0, mem_read, mem_write}, 0);
    n = 0;
    while (!mem_read && n < 20) begin next_cycle(); n++; end
    chk("s1_fetch_seen", {31'b0, mem_read}, 1);
    chk("s1_fetch_addr", {26'b0, mem_address}, 32'h00);
    chk("s1_fetch_busy", {31'b0, cpu_busywait}, 1);
    n = 0;
    while (cpu_busywait && n < 20) begin next_cycle(); n++; end
    chk("s1_done", {31'b0, cpu_busywait}, 0);
    chk("s1_rdata", {24'b0, cpu_readdata}, 32'h11);

    // Scenarios 2-3: single-cycle hit vectors
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      cpu_read = vecs[i].rd; cpu_write = vecs[i].wr;
      cpu_address = vecs[i].addr; cpu_writedata = vecs[i].wdata;
      #1;
      chk({vecs[i].name, "_busy"}, {31'b0, cpu_busywait}, {31'b0, vecs[i].exp_busy});
      chk({vecs[i].name, "_rdata"}, {24'b0, cpu_readdata}, {24'b0, vecs[i].exp_rdata});
      chk({vecs[i].name, "_memreq"}, {30'b0, mem_read, mem_write}, 0);
    end

    // Scenario 4: dirty miss on 0x22, two busy cycles per memory access
    @(negedge clock);
    mem_latency = 2;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 8'h22;
    #1;
    chk("s4_busy_idle", {31'b0, cpu_busywait}, 1);
    chk("s4_no_req_idle", {30'b0, mem_read, mem_write}, 0);
    n = 0;
    while (!mem_write && n < 20) begin next_cycle(); n++; end
    chk("s4_wb_seen", {31'b0, mem_write}, 1);
    chk("s4_wb_addr", {26'b0, mem_address}, 32'h00);
    chk("s4_wb_data", mem_writedata, 32'h44AB2211);
    chk("s4_wb_no_read", {31'b0, mem_read}, 0);
    n = 0;
    while (!mem_read && n < 20) begin next_cycle(); n++; end
    chk("s4_fetch_seen", {31'b0, mem_read}, 1);
    chk("s4_fetch_addr", {26'b0, mem_address}, 32'h08);
    chk("s4_fetch_no_write", {31'b0, mem_write}, 0);
    chk("s4_wb_committed_addr", {26'b0, wb_addr}, 32'h00);
    chk("s4_wb_committed_data", wb_data, 32'h44AB2211);
    n = 0;
    while (cpu_busywait && n < 20) begin next_cycle(); n++; end
    chk("s4_done", {31'b0, cpu_busywait}, 0);
    chk("s4_rdata", {24'b0, cpu_readdata}, 32'h77);

    @(negedge clock);
    cpu_read = 1'b0;
    #1;
`ifdef DCACHE_PERF_EN
    chk("perf_hit_count", {16'b0, hit_count}, 3);
    chk("perf_miss_count", {16'b0, miss_count}, 2);
`endif

    // Read and write together act as a store
    @(negedge clock);
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 8'h21; cpu_writedata = 8'hCD;
    #1;
    chk("rw_busy", {31'b0, cpu_busywait}, 0);
    @(negedge clock);
    cpu_write = 1'b0;
    #1;
    chk("rw_readback", {24'b0, cpu_readdata}, 32'hCD);

    // Reset during FETCH
    @(negedge clock);
    mem_latency = 3;
    cpu_address = 8'h40;
    n = 0;
    while (!mem_read && n < 20) begin next_cycle(); n++; end
    chk("rst_fetch_seen", {31'b0, mem_read}, 1);
    cpu_read = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_async_mem_read", {31'b0, mem_read}, 0);
    chk("rst_async_busy", {31'b0, cpu_busywait}, 0);
    chk("rst_async_mem_write", {31'b0, mem_write}, 0);
    @(negedge clock);
    reset = 1'b0;
    mem_latency = 1;
    cpu_read = 1'b1; cpu_address = 8'h00;
    #1;
    chk("post_rst_miss", {31'b0, cpu_busywait}, 1);
    n = 0;
    while (!(mem_read || mem_write) && n < 20) begin next_cycle(); n++; end
    chk("post_rst_fetch_first", {30'b0, mem_read, mem_write}, 32'h2);
    chk("post_rst_fetch_addr", {26'b0, mem_address}, 32'h00);
    n = 0;
    while (cpu_busywait && n < 20) begin next_cycle(); n++; end
    chk("post_rst_done", {31'b0, cpu_busywait}, 0);
    chk("post_rst_rdata", {24'b0, cpu_readdata}, 32'h11);
    @(negedge clock);
    cpu_read = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
